// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types for the unified memory port arbiter.
//   arb_state_t : FSM state encoding (IDLE, ACCESS, WAIT, RESP)
//   port_id_t   : requester identifier, PORT_CPU = MIPS core, PORT_LDR = loader/debug
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles both requester ports and the memory port.
//   req0_* / rsp0_* : MIPS core port       req1_* / rsp1_* : loader/debug port
//   mem_*           : unified memory port   busy            : arbiter not idle
//   modport slave  : the arbiter's view
//   modport master : the view of whatever drives requests and models memory
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req0_ready;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;

    logic          req1_valid;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          req1_ready;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request vector (already qualified by the caller)
//   advance    : when high and a grant is issued, the grant is remembered
//   gnt[1:0]   : one-hot grant or zero, combinational from req and last_grant
// last_grant resets to the loader port so the core wins the first tie.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    port_id_t last_grant_r;

    // Grant decode: a lone request wins outright, a tie goes to the other port.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b00:   gnt = 2'b00;
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (last_grant_r == PORT_LDR) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

    // Remember the most recent winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= PORT_LDR;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant_r <= gnt[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the MIPS core (port 0)
// and the loader/debug master (port 1), one transaction at a time.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_port_arbiter_if.slave (request, response and memory ports)
// Sequence: IDLE (accept, ready pulse) -> ACCESS (mem_en) -> WAIT x MEM_LAT
// (reads only) -> RESP (response pulse) -> IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
)(
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int CW = $clog2(MEM_LAT + 1);

    arb_state_t    state_r;
    arb_state_t    state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    port_id_t      id_r;

    logic          mem_en_r;
    logic          mem_we_r;
    logic          busy_r;
    logic          rsp0_valid_r;
    logic          rsp1_valid_r;
    logic [DW-1:0] rdata0_r;
    logic [DW-1:0] rdata1_r;

    logic          advance_s;
    logic [1:0]    req_s;
    logic [1:0]    gnt_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    // Requests are only considered in IDLE; reset suppresses acceptance so a
    // requester never sees a ready for a transaction that is thrown away.
    assign advance_s = (state_r == IDLE) && !reset;
    assign req_s     = {bus.req1_valid, bus.req0_valid} & {2{advance_s}};

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_s),
        .advance (advance_s),
        .gnt     (gnt_s)
    );

    assign bus.req0_ready = gnt_s[0];
    assign bus.req1_ready = gnt_s[1];

    // Select the fields of the granted requester.
    always_comb begin
        if (gnt_s[1]) begin
            sel_we_s    = bus.req1_we;
            sel_addr_s  = bus.req1_addr;
            sel_wdata_s = bus.req1_wdata;
        end else begin
            sel_we_s    = bus.req0_we;
            sel_addr_s  = bus.req0_addr;
            sel_wdata_s = bus.req0_wdata;
        end
    end

    // Next-state and latency counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (gnt_s != 2'b00) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (we_r) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                    cnt_s   = CW'(MEM_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_r == '0) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                    cnt_s   = cnt_r - CW'(1);
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            id_r         <= PORT_CPU;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            busy_r       <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rdata0_r     <= '0;
            rdata1_r     <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (gnt_s != 2'b00) begin
                we_r    <= sel_we_s;
                addr_r  <= sel_addr_s;
                wdata_r <= sel_wdata_s;
                id_r    <= gnt_s[1];
            end
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            mem_en_r     <= (state_s == ACCESS);
            mem_we_r     <= (state_s == ACCESS) && sel_we_s;
            busy_r       <= (state_s != IDLE);
            rsp0_valid_r <= (state_s == RESP) && (id_r == PORT_CPU);
            rsp1_valid_r <= (state_s == RESP) && (id_r == PORT_LDR);
            // Last WAIT cycle: memory data is valid now.
            if ((state_r == WAIT) && (cnt_r == '0)) begin
                if (id_r == PORT_CPU) begin
                    rdata0_r <= bus.mem_rdata;
                end else begin
                    rdata1_r <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en     = mem_en_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = addr_r;
    assign bus.mem_wdata  = wdata_r;
    assign bus.busy       = busy_r;
    assign bus.rsp0_valid = rsp0_valid_r;
    assign bus.rsp1_valid = rsp1_valid_r;
    assign bus.rsp0_rdata = rdata0_r;
    assign bus.rsp1_rdata = rdata1_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two instances (MEM_LAT=2 and
// MEM_LAT=1) share stimulus; sel chooses which one is active. A
// transaction-level reference model predicts every cycle's outputs.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [1:0]  v;
    logic        we_d   [2];
    logic [31:0] addr_d [2];
    logic [31:0] wd_d   [2];
    logic [31:0] mem_rdata_drv;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus2 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    assign bus2.req0_valid = v[0] & ~sel;
    assign bus2.req1_valid = v[1] & ~sel;
    assign bus1.req0_valid = v[0] & sel;
    assign bus1.req1_valid = v[1] & sel;
    assign bus2.req0_we = we_d[0];     assign bus1.req0_we = we_d[0];
    assign bus2.req1_we = we_d[1];     assign bus1.req1_we = we_d[1];
    assign bus2.req0_addr = addr_d[0]; assign bus1.req0_addr = addr_d[0];
    assign bus2.req1_addr = addr_d[1]; assign bus1.req1_addr = addr_d[1];
    assign bus2.req0_wdata = wd_d[0];  assign bus1.req0_wdata = wd_d[0];
    assign bus2.req1_wdata = wd_d[1];  assign bus1.req1_wdata = wd_d[1];
    assign bus2.mem_rdata = mem_rdata_drv;
    assign bus1.mem_rdata = mem_rdata_drv;

    wire [1:0]  o_ready = sel ? {bus1.req1_ready, bus1.req0_ready} : {bus2.req1_ready, bus2.req0_ready};
    wire [1:0]  o_rsp   = sel ? {bus1.rsp1_valid, bus1.rsp0_valid} : {bus2.rsp1_valid, bus2.rsp0_valid};
    wire [31:0] o_rd0   = sel ? bus1.rsp0_rdata : bus2.rsp0_rdata;
    wire [31:0] o_rd1   = sel ? bus1.rsp1_rdata : bus2.rsp1_rdata;
    wire        o_en    = sel ? bus1.mem_en : bus2.mem_en;
    wire        o_we    = sel ? bus1.mem_we : bus2.mem_we;
    wire [31:0] o_addr  = sel ? bus1.mem_addr : bus2.mem_addr;
    wire [31:0] o_wdata = sel ? bus1.mem_wdata : bus2.mem_wdata;
    wire        o_busy  = sel ? bus1.busy : bus2.busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int lat   = 2;

    req_t q0[$];
    req_t q1[$];
    int   acc_c[$];
    int   acc_p[$];
    int   rsp_c[$];
    int   rsp_p[$];

    // Reference memory (updated by the model) and simulated memory (updated
    // from the DUT's memory port).
    logic [31:0] refmem [256];
    logic [31:0] simmem [256];
    bit          rd_pend = 1'b0;
    int          rd_c    = 0;
    logic [31:0] rd_a    = 32'h0;

    // Transaction-level model state.
    bit          m_pend = 1'b0;
    int          m_t    = 0;
    int          m_rspc = 0;
    int          m_next = 0;
    bit          m_p    = 1'b0;
    bit          m_we   = 1'b0;
    bit          m_last = 1'b1;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wd   = 32'h0;
    logic [31:0] m_rd   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input bit p, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.we = w; r.addr = a; r.wd = d;
        if (p) q1.push_back(r); else q0.push_back(r);
    endtask

    task automatic clear_logs();
        acc_c.delete(); acc_p.delete(); rsp_c.delete(); rsp_p.delete();
    endtask

    // One clock cycle: drive, sample at negedge, predict, compare.
    task automatic step();
        logic [1:0] e_rdy;
        logic [1:0] e_rsp;
        logic       e_en;
        logic       e_we;
        logic       e_busy;
        bit         p;
        if (q0.size() > 0) begin
            v[0] = 1'b1; we_d[0] = q0[0].we; addr_d[0] = q0[0].addr; wd_d[0] = q0[0].wd;
        end else begin
            v[0] = 1'b0;
        end
        if (q1.size() > 0) begin
            v[1] = 1'b1; we_d[1] = q1[0].we; addr_d[1] = q1[0].addr; wd_d[1] = q1[0].wd;
        end else begin
            v[1] = 1'b0;
        end
        if (rd_pend && cyc == rd_c) begin
            mem_rdata_drv = simmem[rd_a[9:2]];
            rd_pend = 1'b0;
        end else begin
            mem_rdata_drv = $urandom;
        end
        @(negedge clk);
        e_rdy = 2'b00; e_rsp = 2'b00; e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0;
        if (m_pend) begin
            e_busy = (cyc > m_t) && (cyc <= m_rspc);
            if (cyc == m_t + 1) begin
                e_en = 1'b1;
                e_we = m_we;
                if (m_we) chk("mem_wdata", o_wdata, m_wd);
            end
            if (cyc > m_t && cyc < m_rspc) chk("mem_addr", o_addr, m_addr);
            if (cyc == m_rspc) begin
                e_rsp[m_p] = 1'b1;
                if (!m_we) m_rd[m_p] = refmem[m_addr[9:2]];
                m_pend = 1'b0;
            end
        end
        if (!reset && cyc >= m_next && v != 2'b00) begin
            p = (v == 2'b11) ? ~m_last : v[1];
            e_rdy[p] = 1'b1;
            m_pend = 1'b1;
            m_t    = cyc;
            m_p    = p;
            m_we   = we_d[p];
            m_addr = addr_d[p];
            m_wd   = wd_d[p];
            m_rspc = cyc + 2 + (m_we ? 0 : lat);
            m_next = m_rspc + 1;
            m_last = p;
            if (m_we) refmem[m_addr[9:2]] = m_wd;
        end
        chk("ready",  {30'd0, o_ready}, {30'd0, e_rdy});
        chk("rsp",    {30'd0, o_rsp},   {30'd0, e_rsp});
        chk("mem_en", {31'd0, o_en},    {31'd0, e_en});
        chk("mem_we", {31'd0, o_we},    {31'd0, e_we});
        chk("busy",   {31'd0, o_busy},  {31'd0, e_busy});
        chk("rdata0", o_rd0, m_rd[0]);
        chk("rdata1", o_rd1, m_rd[1]);
        if (o_ready[0]) begin acc_c.push_back(cyc); acc_p.push_back(0); void'(q0.pop_front()); end
        if (o_ready[1]) begin acc_c.push_back(cyc); acc_p.push_back(1); void'(q1.pop_front()); end
        if (o_rsp[0]) begin rsp_c.push_back(cyc); rsp_p.push_back(0); end
        if (o_rsp[1]) begin rsp_c.push_back(cyc); rsp_p.push_back(1); end
        if (o_en) begin
            if (o_we) begin
                simmem[o_addr[9:2]] = o_wdata;
            end else begin
                rd_pend = 1'b1; rd_c = cyc + lat; rd_a = o_addr;
            end
        end
        if (reset) begin
            m_pend = 1'b0; m_last = 1'b1; m_next = cyc + 1;
            m_rd[0] = 32'h0; m_rd[1] = 32'h0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || cyc < m_next) && n < max) begin
            step();
            n++;
        end
        chk("drain_timeout", {31'd0, (n < max)}, 32'd1);
    endtask

    task automatic random_phase(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) == 0)
                push(1'b0, 1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
            if (q1.size() == 0 && $urandom_range(0, 3) == 0)
                push(1'b1, 1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
            reset = ($urandom_range(0, 249) == 0);
            step();
        end
        reset = 1'b0;
        drain(200);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            refmem[i] = $urandom;
            simmem[i] = refmem[i];
        end
        m_rd[0] = 32'h0; m_rd[1] = 32'h0;
        sel = 1'b0; v = 2'b00; reset = 1'b1; mem_rdata_drv = 32'h0;
        for (int i = 0; i < 2; i++) begin we_d[i] = 1'b0; addr_d[i] = 32'h0; wd_d[i] = 32'h0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   {31'd0, o_busy}, 32'd0);
        chk("rst_mem_en", {31'd0, o_en},   32'd0);
        chk("rst_addr",   o_addr, 32'd0);
        chk("rst_wdata",  o_wdata, 32'd0);
        chk("rst_rdata0", o_rd0, 32'd0);
        chk("rst_rdata1", o_rd1, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: read p0 @0x40
        refmem[8'h10] = 32'hDEADBEEF; simmem[8'h10] = 32'hDEADBEEF;
        clear_logs();
        push(1'b0, 1'b0, 32'h40, 32'h0);
        drain(50);
        chk("t1_rdata0", o_rd0, 32'hDEADBEEF);
        chk("t1_nrsp", rsp_c.size(), 32'd1);
        if (rsp_c.size() == 1 && acc_c.size() == 1) begin
            chk("t1_lat",  rsp_c[0] - acc_c[0], 32'd4);
            chk("t1_port", rsp_p[0], 32'd0);
        end

        // 2: write p1 @0x80
        clear_logs();
        push(1'b1, 1'b1, 32'h80, 32'h12345678);
        drain(50);
        chk("t2_mem", simmem[8'h20], 32'h12345678);
        chk("t2_rdata1", o_rd1, 32'h0);
        if (rsp_c.size() == 1 && acc_c.size() == 1) begin
            chk("t2_lat",  rsp_c[0] - acc_c[0], 32'd2);
            chk("t2_port", rsp_p[0], 32'd1);
        end else begin
            chk("t2_nrsp", rsp_c.size(), 32'd1);
        end

        // 3: both ports hold reads
        clear_logs();
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 1'b0, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0);
            push(1'b1, 1'b0, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0);
        end
        drain(100);
        chk("t3_nacc", acc_c.size(), 32'd4);
        if (acc_c.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_port", acc_p[i], i % 2);
            for (int i = 1; i < 4; i++) chk("t3_gap", acc_c[i] - acc_c[i-1], 32'd5);
        end

        // 4: only p0, three back-to-back reads
        clear_logs();
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0);
        drain(100);
        chk("t4_nacc", acc_c.size(), 32'd3);
        if (acc_c.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("t4_port", acc_p[i], 32'd0);
            chk("t4_t5",  acc_c[1] - acc_c[0], 32'd5);
            chk("t4_t10", acc_c[2] - acc_c[0], 32'd10);
        end

        // 5: reset during WAIT of a p1 read
        clear_logs();
        push(1'b1, 1'b0, 32'h100, 32'h0);
        n = 0;
        while (acc_c.size() == 0 && n < 20) begin step(); n++; end
        chk("t5_accept", {31'd0, (acc_c.size() == 1)}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        push(1'b0, 1'b0, 32'h104, 32'h0);
        push(1'b1, 1'b0, 32'h108, 32'h0);
        drain(100);
        chk("t5_nrsp", rsp_c.size(), 32'd2);
        if (acc_p.size() == 3 && rsp_p.size() == 2) begin
            chk("t5_first", acc_p[1], 32'd0);
            chk("t5_rsp0",  rsp_p[0], 32'd0);
        end

        // 6: MEM_LAT=1 instance
        reset = 1'b1;
        step();
        reset = 1'b0;
        sel = 1'b1; lat = 1;
        refmem[8'h11] = 32'hA5A5_5A5A; simmem[8'h11] = 32'hA5A5_5A5A;
        clear_logs();
        push(1'b0, 1'b0, 32'h44, 32'h0);
        drain(50);
        chk("t6_rdata0", o_rd0, 32'hA5A5_5A5A);
        if (rsp_c.size() == 1 && acc_c.size() == 1) begin
            chk("t6_lat", rsp_c[0] - acc_c[0], 32'd3);
        end else begin
            chk("t6_nrsp", rsp_c.size(), 32'd1);
        end

        // Randomized traffic on both instances
        random_phase(1500);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sel = 1'b0; lat = 2;
        random_phase(1500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
